// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite fetch path.
package pacman_pkg;

    localparam int unsigned SPRITE_SIZE = 16;
    localparam int unsigned SPRITE_LOG2 = $clog2(SPRITE_SIZE);
    localparam int unsigned ROM_AW      = 2 * SPRITE_LOG2;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned COORD_W     = 10;

    localparam logic [IDX_W-1:0] TRANSP_IDX = 5'd1;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that keeps {blank, hs, vs} aligned with the pixel pipeline.
module vga_sync_delay #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic blank_in,
    input  logic hs_in,
    input  logic vs_in,
    output logic blank_out,
    output logic hs_out,
    output logic vs_out
);

    logic [2:0] pipe [DEPTH];

    // Reset value mirrors an idle VGA line: blanked, syncs deasserted (high).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= 3'b011;
            end
        end else begin
            pipe[0] <= {blank_in, hs_in, vs_in};
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign blank_out = pipe[DEPTH-1][2];
    assign hs_out    = pipe[DEPTH-1][1];
    assign vs_out    = pipe[DEPTH-1][0];

endmodule

// File: rtl/fullyopen_sprite_fetch.sv
// Per-pixel sprite box test, direction transform and ROM fetch for the mouth-open Pac-Man frame.
// Three-cycle fixed latency from DrawX/DrawY/sync to index/sprite_on/sync outputs.
module fullyopen_sprite_fetch
    import pacman_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               blank_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [9:0]         pos_x,
    input  logic [9:0]         pos_y,
    input  logic [1:0]         dir,
    input  logic               visible,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [4:0]         rom_data,
    output logic [4:0]         index,
    output logic               sprite_on,
    output logic               blank_out,
    output logic               hs_out,
    output logic               vs_out
);

    localparam int unsigned SW = SPRITE_LOG2;

    logic               vs_prev;
    logic [9:0]         sh_x;
    logic [9:0]         sh_y;
    dir_t               sh_dir;
    logic               sh_vis;

    logic               vs_fall;
    logic [9:0]         eff_x;
    logic [9:0]         eff_y;
    dir_t               eff_dir;
    logic               eff_vis;
    logic [10:0]        du;
    logic [10:0]        dv;
    logic               in_box;
    logic [SW-1:0]      u;
    logic [SW-1:0]      v;
    logic [SW-1:0]      src_u;
    logic [SW-1:0]      src_v;
    logic               in_box_d1;
    logic               in_box_d2;

    // A pixel coinciding with the vsync fall already sees the newly latched frame state.
    assign vs_fall = vs_prev & ~vs_in;
    assign eff_x   = vs_fall ? pos_x : sh_x;
    assign eff_y   = vs_fall ? pos_y : sh_y;
    assign eff_dir = vs_fall ? dir_t'(dir) : sh_dir;
    assign eff_vis = vs_fall ? visible : sh_vis;

    // Zero-extended subtraction: a set bit 10 means the pixel lies left of / above the box.
    assign du = {1'b0, DrawX} - {1'b0, eff_x};
    assign dv = {1'b0, DrawY} - {1'b0, eff_y};
    assign in_box = !du[10] && (du < 11'(SPRITE_SIZE)) &&
                    !dv[10] && (dv < 11'(SPRITE_SIZE)) &&
                    eff_vis && blank_in;

    assign u = du[SW-1:0];
    assign v = dv[SW-1:0];

    // S-1-x is a bitwise inversion because S is a power of two.
    always_comb begin
        src_u = u;
        src_v = v;
        case (eff_dir)
            DIR_RIGHT: begin src_u = u;  src_v = v; end
            DIR_LEFT:  begin src_u = ~u; src_v = v; end
            DIR_UP:    begin src_u = ~v; src_v = u; end
            DIR_DOWN:  begin src_u = v;  src_v = u; end
            default:   begin src_u = u;  src_v = v; end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev   <= 1'b1;
            sh_x      <= '0;
            sh_y      <= '0;
            sh_dir    <= DIR_RIGHT;
            sh_vis    <= 1'b0;
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            in_box_d2 <= 1'b0;
            index     <= '0;
            sprite_on <= 1'b0;
        end else begin
            vs_prev <= vs_in;
            if (vs_fall) begin
                sh_x   <= pos_x;
                sh_y   <= pos_y;
                sh_dir <= dir_t'(dir);
                sh_vis <= visible;
            end
            rom_addr  <= in_box ? {src_v, src_u} : '0;
            in_box_d1 <= in_box;
            in_box_d2 <= in_box_d1;
            index     <= in_box_d2 ? rom_data : '0;
            sprite_on <= in_box_d2 && (rom_data != TRANSP_IDX);
        end
    end

    vga_sync_delay #(
        .DEPTH (3)
    ) u_sync_delay (
        .clk       (Clk),
        .reset     (Reset),
        .blank_in  (blank_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .blank_out (blank_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

endmodule

// File: tb/tb_fullyopen_sprite_fetch.sv
// Scoreboard bench for fullyopen_sprite_fetch: directed sprite cases plus randomized pixels/syncs.
module tb_fullyopen_sprite_fetch;
    import pacman_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [9:0]        DrawX, DrawY, pos_x, pos_y;
    logic              blank_in, hs_in, vs_in, visible;
    logic [1:0]        dir;
    logic [ROM_AW-1:0] rom_addr;
    logic [4:0]        rom_data = '0;
    logic [4:0]        index;
    logic              sprite_on, blank_out, hs_out, vs_out;

    logic [4:0] rom_mem [1 << ROM_AW];

    typedef struct {
        int         tag;
        logic [4:0] idx;
        logic       on;
        logic       b, h, v;
    } exp_t;

    typedef struct {
        int tag;
        int addr;
    } addr_t;

    exp_t  eq[$];
    addr_t aq[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Reference frame state: what the sprite should look like during the current frame.
    bit m_vs_prev = 1'b1;
    int m_px = 0, m_py = 0, m_dir = 0;
    bit m_vis = 1'b0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_mem[rom_addr];

    fullyopen_sprite_fetch dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank_in  (blank_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .dir       (dir),
        .visible   (visible),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .index     (index),
        .sprite_on (sprite_on),
        .blank_out (blank_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // Drive one pixel on the falling edge and push what the sprite rules say must come out.
    task automatic drive(input int x, input int y, input bit b, input bit h, input bit v,
                         input int px, input int py, input int d, input bit vis);
        int u, w, su, sv, addr;
        bit inb;
        exp_t e;
        addr_t a;
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y);
        blank_in = b; hs_in = h; vs_in = v;
        pos_x = 10'(px); pos_y = 10'(py); dir = 2'(d); visible = vis;
        if (m_vs_prev && !v) begin
            m_px = px; m_py = py; m_dir = d; m_vis = vis;
        end
        m_vs_prev = v;
        u = x - m_px;
        w = y - m_py;
        inb = (u >= 0) && (u < int'(SPRITE_SIZE)) && (w >= 0) && (w < int'(SPRITE_SIZE))
              && m_vis && b;
        case (m_dir)
            1:       begin su = int'(SPRITE_SIZE) - 1 - u; sv = w; end
            2:       begin su = int'(SPRITE_SIZE) - 1 - w; sv = u; end
            3:       begin su = w; sv = u; end
            default: begin su = u; sv = w; end
        endcase
        addr = inb ? sv * int'(SPRITE_SIZE) + su : 0;
        a.tag = cyc + 1;
        a.addr = addr;
        aq.push_back(a);
        e.tag = cyc + 3;
        e.idx = inb ? rom_mem[addr] : 5'd0;
        e.on  = inb && (rom_mem[addr] != TRANSP_IDX);
        e.b = b; e.h = h; e.v = v;
        eq.push_back(e);
    endtask

    // Produce a vsync falling edge that latches the given sprite state.
    task automatic latch(input int px, input int py, input int d, input bit vis);
        drive(0, 0, 1'b0, 1'b1, 1'b1, px, py, d, vis);
        drive(0, 0, 1'b0, 1'b1, 1'b0, px, py, d, vis);
        drive(0, 0, 1'b0, 1'b1, 1'b1, px, py, d, vis);
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Reset = 1'b1;
        blank_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        eq.delete();
        aq.delete();
        m_vs_prev = 1'b1;
        m_px = 0; m_py = 0; m_dir = 0; m_vis = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_index", int'(index), 0);
        chk("reset_sprite_on", int'(sprite_on), 0);
        chk("reset_hs_out", int'(hs_out), 1);
        chk("reset_vs_out", int'(vs_out), 1);
        chk("reset_blank_out", int'(blank_out), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Monitor: compare whatever the scoreboard says is due at this edge.
    initial begin
        addr_t a;
        exp_t e;
        forever begin
            @(posedge Clk);
            cyc++;
            #1;
            while (aq.size() > 0 && aq[0].tag <= cyc) begin
                a = aq.pop_front();
                chk("rom_addr", int'(rom_addr), a.addr);
            end
            while (eq.size() > 0 && eq[0].tag <= cyc) begin
                e = eq.pop_front();
                chk("index", int'(index), int'(e.idx));
                chk("sprite_on", int'(sprite_on), int'(e.on));
                chk("blank_out", int'(blank_out), int'(e.b));
                chk("hs_out", int'(hs_out), int'(e.h));
                chk("vs_out", int'(vs_out), int'(e.v));
            end
        end
    end

    initial begin
        int px, py, d, x, y;
        bit vis, vs, hs, b;
        Reset = 1'b1;
        DrawX = '0; DrawY = '0; pos_x = '0; pos_y = '0; dir = '0; visible = 1'b0;
        blank_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        for (int i = 0; i < (1 << ROM_AW); i++) begin
            rom_mem[i] = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom_range(0, 31));
        end
        rom_mem[83] = 5'd7;
        rom_mem[84] = 5'd1;
        rom_mem[58] = 5'd12;
        rom_mem[92] = 5'd19;
        rom_mem[53] = 5'd25;

        apply_reset();

        latch(100, 50, DIR_RIGHT, 1'b1);
        drive(103, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        drive(104, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        drive(99, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        drive(103, 55, 1'b0, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        drive(115, 65, 1'b1, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        drive(116, 65, 1'b1, 1'b1, 1'b1, 100, 50, DIR_RIGHT, 1'b1);
        // Mid-frame position change must not move the sprite.
        drive(103, 55, 1'b1, 1'b1, 1'b1, 200, 50, DIR_RIGHT, 1'b1);
        drive(203, 55, 1'b1, 1'b1, 1'b1, 200, 50, DIR_RIGHT, 1'b1);
        latch(100, 50, DIR_UP, 1'b1);
        drive(103, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_UP, 1'b1);
        latch(100, 50, DIR_LEFT, 1'b1);
        drive(103, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_LEFT, 1'b1);
        latch(100, 50, DIR_DOWN, 1'b1);
        drive(103, 55, 1'b1, 1'b1, 1'b1, 100, 50, DIR_DOWN, 1'b1);
        latch(200, 50, DIR_RIGHT, 1'b1);
        drive(103, 55, 1'b1, 1'b1, 1'b1, 200, 50, DIR_RIGHT, 1'b1);
        drive(203, 55, 1'b1, 1'b1, 1'b1, 200, 50, DIR_RIGHT, 1'b1);
        // Pixel in the same cycle as the vsync fall uses the new position.
        drive(0, 0, 1'b1, 1'b1, 1'b1, 300, 60, DIR_RIGHT, 1'b1);
        drive(303, 65, 1'b1, 1'b1, 1'b0, 300, 60, DIR_RIGHT, 1'b1);
        drive(0, 0, 1'b1, 1'b1, 1'b1, 300, 60, DIR_RIGHT, 1'b1);
        latch(0, 0, DIR_RIGHT, 1'b0);
        drive(5, 5, 1'b1, 1'b1, 1'b1, 0, 0, DIR_RIGHT, 1'b0);

        px = 100; py = 50; d = 0; vis = 1'b1; vs = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                px = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6)
                                                 : $urandom_range(0, H_VISIBLE - 1);
                py = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6)
                                                 : $urandom_range(0, V_VISIBLE - 1);
                d = $urandom_range(0, 3);
                vis = ($urandom_range(0, 5) != 0);
            end
            if ($urandom_range(0, 39) == 0) vs = ~vs;
            hs = ($urandom_range(0, 15) != 0);
            b = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end else begin
                x = (m_px + $urandom_range(0, 23) - 4) & 1023;
                y = (m_py + $urandom_range(0, 23) - 4) & 1023;
            end
            drive(x, y, b, hs, vs, px, py, d, vis);
            if (n == 2500) begin
                apply_reset();
                vs = 1'b1;
            end
        end

        repeat (6) @(negedge Clk);
        chk("scoreboard_drained", eq.size() + aq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
